host_cmd_rx: RTL

Host-to-FPGA command receiver for the trace-capture platform. It consumes the byte stream from `uart_rx` and parses framed commands from the PC: key, plaintext, sensor delay, and start. Validated fields are committed to registers that drive the cipher/main FSM. Each frame is answered with a one-byte ACK or NAK that the main FSM forwards to `uart_tx`.

---
 rtl/host_cmd_pkg.sv | 37 +++
 rtl/host_cmd_rx_if.sv | 18 +
 rtl/host_cmd_timeout.sv | 26 ++
 rtl/host_cmd_rx.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/host_cmd_pkg.sv
// Shared constants, parser state encoding and payload-length helper for the host command receiver.
package host_cmd_pkg;

  localparam logic [7:0] SyncByte   = 8'hA5;
  localparam logic [7:0] AckByte    = 8'h06;
  localparam logic [7:0] NakByte    = 8'h15;

  localparam logic [7:0] OpSetKey   = 8'h01;
  localparam logic [7:0] OpSetPt    = 8'h02;
  localparam logic [7:0] OpSetDelay = 8'h03;
  localparam logic [7:0] OpStart    = 8'h04;

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StPayload,
    StCheck,
    StCommit,
    StResp
  } state_e;

  function automatic logic op_known(input logic [7:0] op);
    return op inside {OpSetKey, OpSetPt, OpSetDelay, OpStart};
  endfunction

  function automatic int unsigned payload_len(input logic [7:0]  op,
                                              input int unsigned key_size,
                                              input int unsigned block_size);
    case (op)
      OpSetKey:   return key_size / 8;
      OpSetPt:    return block_size / 8;
      OpSetDelay: return 1;
      default:    return 0;
    endcase
  endfunction

endpackage

// File: rtl/host_cmd_rx_if.sv
// Byte-stream and response handshake between uart_rx / main FSM (master) and the receiver (slave).
interface host_cmd_rx_if;
  logic       rx_valid;
  logic [7:0] rx_byte;
  logic       resp_valid;
  logic [7:0] resp_byte;
  logic       resp_ready;

  modport master (
    output rx_valid, rx_byte, resp_ready,
    input  resp_valid, resp_byte
  );

  modport slave (
    input  rx_valid, rx_byte, resp_ready,
    output resp_valid, resp_byte
  );
endinterface

// File: rtl/host_cmd_timeout.sv
// Inter-byte gap counter: counts while enabled, clears on each byte, flags TIMEOUT_CYCLES-1.
module host_cmd_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 1 << 20
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic clr_i,
  output logic tc_o
);
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tc_o = en_i && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    if (!en_i || clr_i || tc_o) cnt_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
endmodule

// File: rtl/host_cmd_rx.sv
// Host command receiver: parses A5-framed commands, commits key/pt/delay/start and answers ACK/NAK.
// Define HOST_CMD_CHECKSUM_EN to require a trailing XOR (CHK) byte on every known frame.
module host_cmd_rx
  import host_cmd_pkg::*;
#(
  parameter int unsigned KEY_SIZE       = 64,
  parameter int unsigned BLOCK_SIZE     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1 << 20,
  parameter int unsigned DELAY_RESET    = 15
) (
  input  logic                  clk,
  input  logic                  c10_resetn,
  host_cmd_rx_if.slave          bus,
  input  logic                  core_busy,
  output logic [KEY_SIZE-1:0]   key,
  output logic [BLOCK_SIZE-1:0] pt,
  output logic [7:0]            delay,
  output logic                  key_load,
  output logic                  pt_load,
  output logic                  delay_load,
  output logic                  start,
  output logic                  err_timeout,
  output logic                  rx_drop
);
  localparam int unsigned ShW  = (KEY_SIZE > BLOCK_SIZE) ? KEY_SIZE : BLOCK_SIZE;
  localparam int unsigned CntW = $clog2(ShW / 8 + 1);

`ifdef HOST_CMD_CHECKSUM_EN
  localparam state_e StAfterPayload = StCheck;
  logic [7:0] xor_q;
`else
  localparam state_e StAfterPayload = StCommit;
`endif

  state_e                state_q;
  logic [7:0]            op_q;
  logic [CntW-1:0]       cnt_q;
  logic [CntW-1:0]       len;
  logic [ShW-1:0]        shadow_q;
  logic [KEY_SIZE-1:0]   key_q;
  logic [BLOCK_SIZE-1:0] pt_q;
  logic [7:0]            delay_q;
  logic                  key_load_q, pt_load_q, delay_load_q, start_q;
  logic                  err_timeout_q, rx_drop_q;
  logic                  resp_valid_q;
  logic [7:0]            resp_byte_q;
  logic                  in_frame, tmo;

  assign len      = CntW'(payload_len(bus.rx_byte, KEY_SIZE, BLOCK_SIZE));
  assign in_frame = (state_q == StCmd) || (state_q == StPayload) || (state_q == StCheck);

  host_cmd_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i (clk),
    .rst_ni(c10_resetn),
    .en_i  (in_frame),
    .clr_i (bus.rx_valid),
    .tc_o  (tmo)
  );

  always_ff @(posedge clk) begin
    if (!c10_resetn) begin
      state_q       <= StIdle;
      op_q          <= '0;
      cnt_q         <= '0;
      shadow_q      <= '0;
      key_q         <= '0;
      pt_q          <= '0;
      delay_q       <= 8'(DELAY_RESET);
      key_load_q    <= 1'b0;
      pt_load_q     <= 1'b0;
      delay_load_q  <= 1'b0;
      start_q       <= 1'b0;
      err_timeout_q <= 1'b0;
      rx_drop_q     <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_byte_q   <= '0;
`ifdef HOST_CMD_CHECKSUM_EN
      xor_q         <= '0;
`endif
    end else begin
      key_load_q    <= 1'b0;
      pt_load_q     <= 1'b0;
      delay_load_q  <= 1'b0;
      start_q       <= 1'b0;
      err_timeout_q <= 1'b0;
      rx_drop_q     <= 1'b0;
      unique case (state_q)
        StIdle: if (bus.rx_valid && bus.rx_byte == SyncByte) state_q <= StCmd;
        StCmd, StPayload, StCheck: begin
          // A byte arriving on the terminal-count cycle is dropped with the frame.
          if (tmo) begin
            err_timeout_q <= 1'b1;
            shadow_q      <= '0;
            state_q       <= StIdle;
          end else if (bus.rx_valid) begin
            if (state_q == StCmd) begin
              if (op_known(bus.rx_byte)) begin
                op_q    <= bus.rx_byte;
                cnt_q   <= len;
                state_q <= (len == '0) ? StAfterPayload : StPayload;
`ifdef HOST_CMD_CHECKSUM_EN
                xor_q   <= bus.rx_byte;
`endif
              end else begin
                resp_byte_q  <= NakByte;
                resp_valid_q <= 1'b1;
                state_q      <= StResp;
              end
            end else if (state_q == StPayload) begin
              shadow_q <= {shadow_q[ShW-9:0], bus.rx_byte};
              cnt_q    <= cnt_q - CntW'(1);
              if (cnt_q == CntW'(1)) state_q <= StAfterPayload;
`ifdef HOST_CMD_CHECKSUM_EN
              xor_q    <= xor_q ^ bus.rx_byte;
`endif
            end else begin
`ifdef HOST_CMD_CHECKSUM_EN
              if (bus.rx_byte == xor_q) begin
                state_q <= StCommit;
              end else begin
                resp_byte_q  <= NakByte;
                resp_valid_q <= 1'b1;
                state_q      <= StResp;
              end
`else
              state_q <= StIdle;
`endif
            end
          end
        end
        StCommit: begin
          resp_byte_q  <= AckByte;
          resp_valid_q <= 1'b1;
          state_q      <= StResp;
          case (op_q)
            OpSetKey:   begin key_q   <= shadow_q[KEY_SIZE-1:0];   key_load_q   <= 1'b1; end
            OpSetPt:    begin pt_q    <= shadow_q[BLOCK_SIZE-1:0]; pt_load_q    <= 1'b1; end
            OpSetDelay: begin delay_q <= shadow_q[7:0];            delay_load_q <= 1'b1; end
            default: begin
              if (core_busy) resp_byte_q <= NakByte;
              else           start_q     <= 1'b1;
            end
          endcase
        end
        StResp: begin
          rx_drop_q <= bus.rx_valid;
          if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            state_q      <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign key            = key_q;
  assign pt             = pt_q;
  assign delay          = delay_q;
  assign key_load       = key_load_q;
  assign pt_load        = pt_load_q;
  assign delay_load     = delay_load_q;
  assign start          = start_q;
  assign err_timeout    = err_timeout_q;
  assign rx_drop        = rx_drop_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_byte  = resp_byte_q;
endmodule
